// File: rtl/add_16_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder among N requesters.
// A grant latches operands in IDLE, sums in EXEC, and holds the result in RESP until taken.

module add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module add_16_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    resp_valid,
  input  logic [N-1:0]    resp_ready,
  output logic [15:0]     resp_sum,
  output logic [IDW-1:0]  grant_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] last, grant_q, pick, idx;
  logic           pick_found;
  logic [15:0]    op_a, op_b, sum_q, add_sum;
  logic [15:0]    a_slice [N];
  logic [15:0]    b_slice [N];

  add_16 u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_slice[i] = req_a[16*i +: 16];
      b_slice[i] = req_b[16*i +: 16];
    end
  end

  // Scan starts just after the last served requester, so it becomes lowest priority.
  always_comb begin
    pick       = '0;
    idx        = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last) + k) % N);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready[grant_q]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last    <= IDW'(N - 1);
      grant_q <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
    end else begin
      if (state == IDLE && pick_found) begin
        op_a    <= a_slice[pick];
        op_b    <= b_slice[pick];
        grant_q <= pick;
      end
      if (state == EXEC) sum_q <= add_sum;
      if (state == RESP && resp_ready[grant_q]) last <= grant_q;
    end
  end

  assign req_ready  = (state == IDLE && pick_found) ? (N'(1) << pick) : '0;
  assign resp_valid = (state == RESP) ? (N'(1) << grant_q) : '0;
  assign resp_sum   = sum_q;
  assign grant_id   = grant_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_add_16_arbiter.sv
// Randomized bench for add_16_arbiter: a transaction-level model predicts grants and sums,
// pushing expected responses into a scoreboard that a negedge monitor drains.

module tb_add_16_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [15:0]     resp_sum;
  logic [IDW-1:0]  grant_id;
  logic            busy;

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   checking = 0;
  bit   pop_pending = 0;

  // Model: 0 = free, 1 = adding, 2 = holding result
  int m_state = 0;
  int m_last  = N - 1;
  int m_grant = 0;
  int m_sum   = 0;
  int m_pend  = 0;

  add_16_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick_winner();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N] === 1'b1) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic int operand(input logic [16*N-1:0] bus, input int id);
    logic [15:0] s;
    s = 16'(bus >> (16 * id));
    return int'(s);
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin : model
    int w;
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        m_state = 0;
        m_last  = N - 1;
        m_grant = 0;
        m_sum   = 0;
        sb.delete();
      end else begin
        case (m_state)
          0: begin
            w = pick_winner();
            if (w >= 0) begin
              m_grant = w;
              m_pend  = (operand(req_a, w) + operand(req_b, w)) % 65536;
              sb.push_back('{w, m_pend});
              m_state = 1;
            end
          end
          1: begin
            m_sum   = m_pend;
            m_state = 2;
          end
          default: begin
            if (resp_ready[m_grant] === 1'b1) begin
              m_last  = m_grant;
              m_state = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic checkOutput();
    int w;
    logic [N-1:0] exp_ready, exp_valid;
    w         = (m_state == 0) ? pick_winner() : -1;
    exp_ready = (w >= 0) ? (N'(1) << w) : '0;
    exp_valid = (m_state == 2) ? (N'(1) << m_grant) : '0;
    compare("req_ready", 32'(req_ready), 32'(exp_ready));
    compare("busy", 32'(busy), 32'(m_state != 0));
    compare("grant_id", 32'(grant_id), 32'(m_grant));
    compare("resp_sum_held", 32'(resp_sum), 32'(m_sum));
    compare("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (resp_valid !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got resp_valid %0h expected no response", resp_valid);
      end else begin
        compare("resp_onehot", 32'(resp_valid), 32'(N'(1) << sb[0].id));
        compare("resp_sum", 32'(resp_sum), 32'(sb[0].sum));
        if ((resp_valid & resp_ready) != '0) pop_pending = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) checkOutput();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (pop_pending) begin
        if (rst_n === 1'b1 && sb.size() > 0) void'(sb.pop_front());
        pop_pending = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] rr);
    req_valid  = v;
    resp_ready = rr;
  endtask

  task automatic setOperand(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
  endtask

  task automatic randomizeOperands();
    for (int i = 0; i < N; i++) setOperand(i, 16'($urandom), 16'($urandom));
  endtask

  task automatic sendOne(input int id, input logic [15:0] a, input logic [15:0] b, input logic [N-1:0] rr);
    bit done = 0;
    setOperand(id, a, b);
    applyStimulus(N'(1) << id, rr);
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (busy === 1'b1) done = 1;
    end
    req_valid = '0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got busy %b expected 1 for requester %0d", busy, id);
    end
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      if (busy === 1'b0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    rst_n    = 1'b1;
    checking = 1;

    $display("[TB] single request from requester 0");
    sendOne(0, 16'h0003, 16'h0004, '1);
    waitIdle();

    $display("[TB] wrap-around sums on requester 2");
    sendOne(2, 16'hFFFF, 16'h0001, '1);
    waitIdle();
    sendOne(2, 16'h8000, 16'h8000, '1);
    waitIdle();

    $display("[TB] round robin with all requesters active");
    applyStimulus('1, '1);
    for (int c = 0; c < 16; c++) begin
      randomizeOperands();
      tick();
    end
    applyStimulus('0, '1);
    waitIdle();

    $display("[TB] backpressure on requester 1");
    sendOne(1, 16'h1111, 16'h2222, 4'b1101);
    for (int c = 0; c < 7; c++) tick();
    applyStimulus('0, '1);
    waitIdle();

    $display("[TB] reset while holding a response");
    sendOne(2, 16'h0ABC, 16'h0001, '0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus('1, '1);
    for (int c = 0; c < 7; c++) tick();
    applyStimulus('0, '1);
    waitIdle();

    $display("[TB] operand change after acceptance");
    sendOne(1, 16'h0010, 16'h0001, '1);
    setOperand(1, 16'h1234, 16'h0001);
    waitIdle();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      randomizeOperands();
      applyStimulus(N'($urandom), N'($urandom));
      tick();
    end
    applyStimulus('0, '1);
    waitIdle();
    tick();
    tick();

    compare("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
